// File: rtl/zigzag_pingpong_ctrl.sv
// Ping-pong controller between a raster-order 4x4 coefficient source and a zigzag scanner.
// One BRAM bank is filled while the other is drained in zigzag order through a 2-entry output FIFO.
module zigzag_pingpong_ctrl #(
  parameter int WIDTH     = 9,
  parameter int addrWIDTH = 4,
  parameter int DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic                 ena0,
  output logic                 ena1,
  output logic                 wea0,
  output logic                 wea1,
  output logic [addrWIDTH-1:0] addra0,
  output logic [addrWIDTH-1:0] addra1,
  output logic [WIDTH-1:0]     dia0,
  output logic [WIDTH-1:0]     dia1,
  output logic                 enb0,
  output logic                 enb1,
  output logic [addrWIDTH-1:0] addrb0,
  output logic [addrWIDTH-1:0] addrb1,
  input  logic [WIDTH-1:0]     dob0,
  input  logic [WIDTH-1:0]     dob1
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bankState_t;

  localparam logic [3:0] LAST_IDX = 4'(DEPTH - 1);
  localparam logic [3:0] ZZ [16] = '{4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
                                     4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15};

  bankState_t       bankState_q [2];
  bankState_t       bankState_d [2];
  logic             wrSel_q, wrSel_d;
  logic             rdSel_q, rdSel_d;
  logic [3:0]       wrCnt_q, wrCnt_d;
  logic [3:0]       rdCnt_q, rdCnt_d;
  logic             inflight_q, inflight_d;
  logic             inflightBank_q, inflightBank_d;
  logic             inflightLast_q, inflightLast_d;
  logic [1:0]       fifoCount_q, fifoCount_d;
  logic [WIDTH-1:0] fifoData_q [2];
  logic [WIDTH-1:0] fifoData_d [2];
  logic             fifoLast_q [2];
  logic             fifoLast_d [2];

  logic                 active;
  logic                 doWrite;
  logic                 canRead;
  logic                 doRead;
  logic                 pop;
  logic                 pushSlot;
  logic [3:0]           wrAddr;
  logic [addrWIDTH-1:0] rdAddr;
  logic [WIDTH-1:0]     pushData;

  assign active   = rst & ~flush;
  assign in_ready = (bankState_q[wrSel_q] == EMPTY) || (bankState_q[wrSel_q] == FILLING);
  assign doWrite  = active & in_valid & in_ready;
  assign canRead  = (bankState_q[rdSel_q] == FULL) || (bankState_q[rdSel_q] == DRAINING);
  assign pop      = out_valid & out_ready;

  // Issue only if the FIFO can still hold the result after this cycle's pop lands.
  assign doRead = active & canRead &
                  (({1'b0, fifoCount_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

  assign wrAddr   = wrCnt_q + 4'd1;
  assign rdAddr   = addrWIDTH'(ZZ[rdCnt_q]);
  assign pushData = inflightBank_q ? dob1 : dob0;
  assign pushSlot = (fifoCount_q == 2'd2) || ((fifoCount_q == 2'd1) && !pop);

  assign ena0   = doWrite & ~wrSel_q;
  assign ena1   = doWrite &  wrSel_q;
  assign wea0   = ena0;
  assign wea1   = ena1;
  assign addra0 = ena0 ? addrWIDTH'(wrAddr) : '0;
  assign addra1 = ena1 ? addrWIDTH'(wrAddr) : '0;
  assign dia0   = ena0 ? in_data : '0;
  assign dia1   = ena1 ? in_data : '0;
  assign enb0   = doRead & ~rdSel_q;
  assign enb1   = doRead &  rdSel_q;
  assign addrb0 = enb0 ? rdAddr : '0;
  assign addrb1 = enb1 ? rdAddr : '0;

  assign out_valid = (fifoCount_q != 2'd0);
  assign out_data  = out_valid ? fifoData_q[0] : '0;
  assign out_last  = out_valid & fifoLast_q[0];

  always_comb begin
    bankState_d    = bankState_q;
    wrSel_d        = wrSel_q;
    rdSel_d        = rdSel_q;
    wrCnt_d        = wrCnt_q;
    rdCnt_d        = rdCnt_q;
    inflight_d     = doRead;
    inflightBank_d = rdSel_q;
    inflightLast_d = (rdCnt_q == LAST_IDX);
    fifoData_d     = fifoData_q;
    fifoLast_d     = fifoLast_q;
    fifoCount_d    = fifoCount_q + {1'b0, inflight_q} - {1'b0, pop};

    if (doWrite) begin
      wrCnt_d              = wrCnt_q + 4'd1;
      bankState_d[wrSel_q] = FILLING;
      if (wrCnt_q == LAST_IDX) begin
        wrCnt_d              = '0;
        bankState_d[wrSel_q] = FULL;
        wrSel_d              = ~wrSel_q;
      end
    end

    // The last issue frees the bank at once; its data is already captured by the BRAM.
    if (doRead) begin
      rdCnt_d              = rdCnt_q + 4'd1;
      bankState_d[rdSel_q] = DRAINING;
      if (rdCnt_q == LAST_IDX) begin
        rdCnt_d              = '0;
        bankState_d[rdSel_q] = EMPTY;
        rdSel_d              = ~rdSel_q;
      end
    end

    if (pop) begin
      fifoData_d[0] = fifoData_q[1];
      fifoLast_d[0] = fifoLast_q[1];
    end
    if (inflight_q) begin
      fifoData_d[pushSlot] = pushData;
      fifoLast_d[pushSlot] = inflightLast_q;
    end

    if (flush) begin
      bankState_d[0] = EMPTY;
      bankState_d[1] = EMPTY;
      wrSel_d        = 1'b0;
      rdSel_d        = 1'b0;
      wrCnt_d        = '0;
      rdCnt_d        = '0;
      inflight_d     = 1'b0;
      inflightBank_d = 1'b0;
      inflightLast_d = 1'b0;
      fifoCount_d    = '0;
      fifoData_d[0]  = '0;
      fifoData_d[1]  = '0;
      fifoLast_d[0]  = 1'b0;
      fifoLast_d[1]  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bankState_q[0] <= EMPTY;
      bankState_q[1] <= EMPTY;
      wrSel_q        <= 1'b0;
      rdSel_q        <= 1'b0;
      wrCnt_q        <= '0;
      rdCnt_q        <= '0;
      inflight_q     <= 1'b0;
      inflightBank_q <= 1'b0;
      inflightLast_q <= 1'b0;
      fifoCount_q    <= '0;
      fifoData_q[0]  <= '0;
      fifoData_q[1]  <= '0;
      fifoLast_q[0]  <= 1'b0;
      fifoLast_q[1]  <= 1'b0;
    end else begin
      bankState_q    <= bankState_d;
      wrSel_q        <= wrSel_d;
      rdSel_q        <= rdSel_d;
      wrCnt_q        <= wrCnt_d;
      rdCnt_q        <= rdCnt_d;
      inflight_q     <= inflight_d;
      inflightBank_q <= inflightBank_d;
      inflightLast_q <= inflightLast_d;
      fifoCount_q    <= fifoCount_d;
      fifoData_q     <= fifoData_d;
      fifoLast_q     <= fifoLast_d;
    end
  end

endmodule

// File: tb/tb_zigzag_pingpong_ctrl.sv
// Bench for zigzag_pingpong_ctrl: behavioural BRAM banks plus a block-level zigzag reference model.
// Expected output order is derived by walking the 4x4 anti-diagonals, not from a copied table.
`timescale 1ns/1ps
module tb_zigzag_pingpong_ctrl;
  localparam int WIDTH = 9;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [WIDTH-1:0] in_data, out_data, dia0, dia1, dob0, dob1;
  logic             ena0, ena1, wea0, wea1, enb0, enb1;
  logic [AW-1:0]    addra0, addra1, addrb0, addrb1;

  always #5 clk = ~clk;

  zigzag_pingpong_ctrl #(.WIDTH(WIDTH), .addrWIDTH(AW), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .ena0(ena0), .ena1(ena1), .wea0(wea0), .wea1(wea1),
    .addra0(addra0), .addra1(addra1), .dia0(dia0), .dia1(dia1),
    .enb0(enb0), .enb1(enb1), .addrb0(addrb0), .addrb1(addrb1),
    .dob0(dob0), .dob1(dob1)
  );

  // Dual-port banks: write port stores at addra-1, read data appears one cycle after enb.
  logic [WIDTH-1:0] mem0 [16];
  logic [WIDTH-1:0] mem1 [16];
  always @(posedge clk) begin
    if (ena0 && wea0) mem0[addra0 - 4'd1] <= dia0;
    if (ena1 && wea1) mem1[addra1 - 4'd1] <= dia1;
    if (enb0) dob0 <= mem0[addrb0];
    if (enb1) dob1 <= mem1[addrb1];
  end

  int assertCount = 0;
  int failCount   = 0;
  int tick        = 0;
  int outCount    = 0;
  int lastInTick, firstValidTick, lastPopTick;
  int blockCount, inIdx, readIssues;
  int zzTab [16];
  logic [WIDTH-1:0] curBlock [16];
  logic [WIDTH:0]   expQ [$];
  logic             sInReady, sOutValid, prevStall, prevLast;
  logic [WIDTH-1:0] prevData;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic buildZigzag();
    int k = 0;
    for (int s = 0; s < 7; s++) begin
      int lo = (s > 3) ? s - 3 : 0;
      int hi = (s < 3) ? s : 3;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin zzTab[k] = r * 4 + (s - r); k++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin zzTab[k] = r * 4 + (s - r); k++; end
      end
    end
  endtask

  task automatic clearModel();
    expQ.delete();
    inIdx      = 0;
    blockCount = 0;
    readIssues = 0;
    prevStall  = 1'b0;
  endtask

  // One clock cycle: drive at negedge, sample 2ns later, update the model, advance to next negedge.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    logic           wrBank;
    logic [WIDTH:0] e;
    in_valid = v; in_data = d; out_ready = r; flush = f;
    #2;
    sInReady  = in_ready;
    sOutValid = out_valid;
    checkOutput("bankClash", 32'({ena0 & enb0, ena1 & enb1}), 32'd0);
    if (prevStall) begin
      checkOutput("stallValid", 32'(out_valid), 32'd1);
      checkOutput("stallData", 32'(out_data), 32'(prevData));
      checkOutput("stallLast", 32'(out_last), 32'(prevLast));
    end
    if (f) begin
      checkOutput("flushEnables", 32'({ena0, ena1, wea0, wea1, enb0, enb1}), 32'd0);
      clearModel();
    end else begin
      if (enb0 || enb1) begin
        checkOutput("enbSel", 32'({enb1, enb0}), ((readIssues / 16) % 2 == 1) ? 32'd2 : 32'd1);
        checkOutput("addrb", 32'(enb1 ? addrb1 : addrb0), 32'(zzTab[readIssues % 16]));
        checkOutput("readAhead", 32'(readIssues < 16 * blockCount), 32'd1);
        readIssues++;
      end
      wrBank = (blockCount % 2 == 1);
      if (v && in_ready) begin
        checkOutput("enaSel", 32'({ena1, ena0}), wrBank ? 32'd2 : 32'd1);
        checkOutput("weaSel", 32'({wea1, wea0}), wrBank ? 32'd2 : 32'd1);
        checkOutput("addra", 32'(wrBank ? addra1 : addra0), 32'((inIdx + 1) % 16));
        checkOutput("dia", 32'(wrBank ? dia1 : dia0), 32'(d));
        curBlock[inIdx] = d;
        inIdx++;
        lastInTick = tick;
        if (inIdx == 16) begin
          for (int k = 0; k < 16; k++) expQ.push_back({k == 15, curBlock[zzTab[k]]});
          inIdx = 0;
          blockCount++;
        end
      end else begin
        checkOutput("idleWrite", 32'({ena0, ena1, wea0, wea1}), 32'd0);
      end
      if (out_valid && firstValidTick < 0) firstValidTick = tick;
      if (out_valid && r) begin
        lastPopTick = tick;
        if (expQ.size() == 0) begin
          checkOutput("spuriousOut", 32'(out_valid), 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("outData", 32'(out_data), 32'(e[WIDTH-1:0]));
          checkOutput("outLast", 32'(out_last), 32'(e[WIDTH]));
          outCount++;
        end
      end
      prevStall = out_valid && !r;
      prevData  = out_data;
      prevLast  = out_last;
    end
    @(posedge clk);
    @(negedge clk);
    tick++;
  endtask

  // Asserts rst mid-cycle (away from any edge) and checks every output asynchronously.
  task automatic resetDut(input logic validDuring);
    in_valid = validDuring; in_data = 9'h1A5; out_ready = 1'b1; flush = 1'b0;
    #3 rst = 1'b0;
    #1;
    checkOutput("rstInReady", 32'(in_ready), 32'd1);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstOutLast", 32'(out_last), 32'd0);
    checkOutput("rstOutData", 32'(out_data), 32'd0);
    checkOutput("rstEnables", 32'({ena0, ena1, wea0, wea1, enb0, enb1}), 32'd0);
    checkOutput("rstAddr", 32'({addra0, addra1, addrb0, addrb1}), 32'd0);
    checkOutput("rstDia", 32'({dia0, dia1}), 32'd0);
    clearModel();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drainAll(input int mode);
    int c = 0;
    logic r;
    while (expQ.size() > 0 && c < 300) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? ((tick % 2) == 0) : 1'($urandom_range(0, 1));
      applyStimulus(1'b0, '0, r, 1'b0);
      c++;
    end
    checkOutput("drainDone", 32'(expQ.size()), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("idleValid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int accepted, drops, stallAt, popped, outBase;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    firstValidTick = -1; lastPopTick = -1; lastInTick = -1;
    buildZigzag();
    clearModel();
    resetDut(1'b0);

    $display("[TB] single block, latency");
    accepted = 0; firstValidTick = -1;
    for (int c = 0; c < 40 && accepted < 16; c++) begin
      applyStimulus(1'b1, WIDTH'(accepted), 1'b1, 1'b0);
      if (sInReady) accepted++;
    end
    checkOutput("t1Accepted", 32'(accepted), 32'd16);
    drainAll(0);
    // out_valid rises two edges after the accepting edge of the 16th input.
    checkOutput("t1Latency", 32'(firstValidTick - lastInTick), 32'd3);
    checkOutput("t1Count", 32'(outCount), 32'd16);

    $display("[TB] three back-to-back blocks");
    accepted = 0; drops = 0; firstValidTick = -1; outBase = outCount;
    for (int c = 0; c < 60 && accepted < 48; c++) begin
      applyStimulus(1'b1, WIDTH'(accepted), 1'b1, 1'b0);
      if (sInReady) accepted++; else drops++;
    end
    checkOutput("t2Accepted", 32'(accepted), 32'd48);
    checkOutput("t2InReadyDrops", 32'(drops), 32'd0);
    drainAll(0);
    checkOutput("t2Count", 32'(outCount - outBase), 32'd48);
    checkOutput("t2Continuous", 32'(lastPopTick - firstValidTick), 32'd47);

    $display("[TB] backpressure");
    accepted = 0; stallAt = -1; outBase = outCount;
    for (int c = 0; c < 400 && accepted < 48; c++) begin
      applyStimulus(1'b1, WIDTH'($urandom), (tick % 2) == 0, 1'b0);
      if (sInReady) accepted++;
      else if (stallAt < 0) stallAt = accepted;
    end
    checkOutput("t3Accepted", 32'(accepted), 32'd48);
    checkOutput("t3StallAt", 32'(stallAt), 32'd32);
    drainAll(1);
    checkOutput("t3Count", 32'(outCount - outBase), 32'd48);

    $display("[TB] flush mid-block");
    accepted = 0; popped = 0; outBase = outCount;
    for (int c = 0; c < 100 && accepted < 22; c++) begin
      applyStimulus(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
      if (sInReady) accepted++;
    end
    for (int c = 0; c < 100 && (outCount - outBase) < 11; c++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
    end
    checkOutput("t4Popped", 32'(outCount - outBase), 32'd11);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t4FlushValid", 32'(sOutValid), 32'd0);
    checkOutput("t4FlushReady", 32'(sInReady), 32'd1);
    accepted = 0; outBase = outCount;
    for (int c = 0; c < 40 && accepted < 16; c++) begin
      applyStimulus(1'b1, WIDTH'($urandom), 1'b1, 1'b0);
      if (sInReady) accepted++;
    end
    drainAll(0);
    checkOutput("t4Count", 32'(outCount - outBase), 32'd16);

    $display("[TB] random traffic");
    for (int c = 0; c < 160; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), WIDTH'($urandom), $urandom_range(0, 3) != 0, 1'b0);
    end
    drainAll(2);

    $display("[TB] reset mid-drain");
    accepted = 0;
    for (int c = 0; c < 40 && accepted < 16; c++) begin
      applyStimulus(1'b1, WIDTH'($urandom), 1'b1, 1'b0);
      if (sInReady) accepted++;
    end
    for (int c = 0; c < 6; c++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    resetDut(1'b1);
    accepted = 0; outBase = outCount;
    for (int c = 0; c < 40 && accepted < 16; c++) begin
      applyStimulus(1'b1, WIDTH'($urandom), 1'b1, 1'b0);
      if (sInReady) accepted++;
    end
    drainAll(0);
    checkOutput("t6Count", 32'(outCount - outBase), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
